// File: rtl/dec_queue.sv
// Instruction queue between fetch and decode; decodes the head entry into control bits.
// Latency: 1 cycle from push to head visibility, no bypass; decode is combinational from the head.
// Backpressure: in_ready = not full (independent of out_ready); flush clears synchronously.
//
// Ports:
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   flush                synchronous clear; discards same-cycle push/pop
//   in_valid/in_ready    fetch handshake, carries in_inst and in_pc
//   out_valid/out_ready  decode handshake, presents out_inst/out_pc of the head
//   out_ctrl             {regwrite,regdst,alusrc,branch,memwrite,memtoreg,jump,link,jr,hilo_write,aluop[1:0]}
//   out_cp0we, out_invalid, out_eret, out_syscall, out_break   head decode flags
//   count                occupancy
module dec_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 12
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [31:0]              in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic [31:0]              out_pc,
  output logic [CW-1:0]            out_ctrl,
  output logic                     out_cp0we,
  output logic                     out_invalid,
  output logic                     out_eret,
  output logic                     out_syscall,
  output logic                     out_break,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

  // Control-word encodings for each instruction class.
  localparam logic [CW-1:0] C_LOAD  = CW'(12'hA40);
  localparam logic [CW-1:0] C_STORE = CW'(12'h280);
  localparam logic [CW-1:0] C_BR    = CW'(12'h101);
  localparam logic [CW-1:0] C_BRAL  = CW'(12'h911);
  localparam logic [CW-1:0] C_J     = CW'(12'h020);
  localparam logic [CW-1:0] C_JAL   = CW'(12'h830);
  localparam logic [CW-1:0] C_ALUI  = CW'(12'hA02);
  localparam logic [CW-1:0] C_ALUR  = CW'(12'hC02);
  localparam logic [CW-1:0] C_HILO  = CW'(12'h006);
  localparam logic [CW-1:0] C_SHIFT = CW'(12'hC01);
  localparam logic [CW-1:0] C_JR    = CW'(12'h028);
  localparam logic [CW-1:0] C_JALR  = CW'(12'hC38);
  localparam logic [CW-1:0] C_MFC0  = CW'(12'h800);

  // Only the instruction word and its address are stored; control is re-derived at the head.
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Pointers are exactly PW bits, so increments wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only observed after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= in_inst;
      pc_mem[wr_ptr]   <= in_pc;
    end
  end

  assign out_inst = inst_mem[rd_ptr];
  assign out_pc   = pc_mem[rd_ptr];

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [5:0] funct;

  assign op    = out_inst[31:26];
  assign rs    = out_inst[25:21];
  assign rt    = out_inst[20:16];
  assign funct = out_inst[5:0];

  // Everything is gated by out_valid so stale storage never leaks onto the decode outputs.
  always_comb begin
    out_ctrl    = '0;
    out_cp0we   = 1'b0;
    out_invalid = 1'b0;
    out_eret    = 1'b0;
    out_syscall = 1'b0;
    out_break   = 1'b0;
    if (out_valid) begin
      casez (op)
        6'b100000, 6'b100001, 6'b100011,
        6'b100100, 6'b100101:            out_ctrl = C_LOAD;
        6'b101000, 6'b101001, 6'b101011: out_ctrl = C_STORE;
        6'b0001??:                       out_ctrl = C_BR;
        6'b000001: begin
          // REGIMM: rt selects plain branch vs. branch-and-link.
          if (rt == 5'b00000 || rt == 5'b00001)      out_ctrl = C_BR;
          else if (rt == 5'b10000 || rt == 5'b10001) out_ctrl = C_BRAL;
          else                                       out_invalid = 1'b1;
        end
        6'b000010:                       out_ctrl = C_J;
        6'b000011:                       out_ctrl = C_JAL;
        6'b001???:                       out_ctrl = C_ALUI;
        6'b000000: begin
          casez (funct)
            6'b100???, 6'b10101?,
            6'b010000, 6'b010010:        out_ctrl = C_ALUR;
            6'b010001, 6'b010011,
            6'b0110??:                   out_ctrl = C_HILO;
            6'b000000, 6'b000010, 6'b000011,
            6'b000100, 6'b000110, 6'b000111: out_ctrl = C_SHIFT;
            6'b001000:                   out_ctrl = C_JR;
            6'b001001:                   out_ctrl = C_JALR;
            6'b001100:                   out_syscall = 1'b1;
            6'b001101:                   out_break = 1'b1;
            default:                     out_invalid = 1'b1;
          endcase
        end
        6'b010000: begin
          case (rs)
            5'b00100: out_cp0we = 1'b1;
            5'b00000: out_ctrl  = C_MFC0;
            5'b10000: out_eret  = 1'b1;
            default:  out_invalid = 1'b1;
          endcase
        end
        default: out_invalid = 1'b1;
      endcase
    end
  end

endmodule

// File: doc/dec_queue.md
DEC_QUEUE -- requirements
Module: dec_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning queue entries; SHALL be a power of two, >= 2.
REQ-002 Parameter CW, default 12, meaning control-word width; values other than 12 are unsupported.
REQ-003 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous queue clear.
- in_valid  in  1  fetch offers instruction.
- in_ready  out  1  queue can accept.
- in_inst  in  32  instruction word.
- in_pc  in  32  instruction address.
- out_valid  out  1  head entry available.
- out_ready  in  1  decode stage consumes head.
- out_inst  out  32  head instruction.
- out_pc  out  32  head address.
- out_ctrl  out  CW  {regwrite,regdst,alusrc,branch,memwrite,memtoreg,jump,link,jr,hilo_write,aluop[1:0]}.
- out_cp0we  out  1  MTC0 write enable.
- out_invalid  out  1  reserved-instruction flag.
- out_eret, out_syscall, out_break  out  1 each  exception-class flags.
- count  out  clog2(DEPTH)+1  occupancy.

Function
REQ-004 Push SHALL occur on a rising edge with in_valid && in_ready && !flush; pop SHALL occur on a rising edge with out_valid && out_ready && !flush.
REQ-005 in_ready SHALL be (count != DEPTH), with no dependence on out_ready; out_valid SHALL be (count != 0).
REQ-006 A pushed entry SHALL be visible at the head no earlier than the next cycle, giving a minimum latency of 1 cycle with no bypass.
REQ-007 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-008 Read and write pointers SHALL be clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-009 While flush=1, the next edge SHALL zero count and both pointers, and SHALL discard any same-cycle push or pop.
REQ-010 Decode SHALL be combinational from the head entry. op=inst[31:26], rs=[25:21], rt=[20:16], funct=[5:0]. out_ctrl values in hex:
- Loads, op 100000/100001/100011/100100/100101: 0xA40.
- Stores, op 101000/101001/101011: 0x280.
- Branches, op 000100/000101/000110/000111: 0x101.
- REGIMM op 000001, rt 00000/00001: 0x101.
- REGIMM op 000001, rt 10000/10001: 0x911.
- J, op 000010: 0x020.
- JAL, op 000011: 0x830.
- Immediate ALU, op 001000..001111: 0xA02.
- op 000000, funct 100000..100011, 100100..100111, 101010, 101011, 010000, 010010: 0xC02.
- op 000000, funct 010001, 010011, 011000..011011: 0x006.
- op 000000, funct 000000, 000010, 000011, 000100, 000110, 000111: 0xC01.
- op 000000, funct 001000 (JR): 0x028.
- op 000000, funct 001001 (JALR): 0xC38.
- op 000000, funct 001100 (SYSCALL): 0x000 with out_syscall=1.
- op 000000, funct 001101 (BREAK): 0x000 with out_break=1.
- op 010000 with rs 00100 (MTC0): 0x000 with out_cp0we=1.
- op 010000 with rs 00000 (MFC0): 0x800.
- op 010000 with rs 10000 (ERET): 0x000 with out_eret=1.
- All other encodings: out_ctrl 0x000 with out_invalid=1.
REQ-011 When out_valid=0, out_ctrl, out_cp0we, out_invalid, out_eret, out_syscall and out_break SHALL all be 0; out_inst and out_pc are don't-care.
REQ-012 Storage SHALL hold only inst and pc; control bits SHALL never be stored.

Reset
REQ-013 When resetn=0, pointers and count SHALL clear immediately without waiting for a clock edge; in_ready SHALL be 1, out_valid SHALL be 0, and all decode outputs SHALL be 0.
REQ-014 A reset asserted mid-operation SHALL discard all entries; the first push after resetn deasserts SHALL become the head.

Verification
REQ-015 Push 0x8C010004 (lw); one cycle later, out_valid=1 and out_ctrl=0xA40. Then push 0x0C000010 (jal) and check out_ctrl=0x830 after the lw is popped.
REQ-016 Hold out_ready=0 and push DEPTH entries: count=DEPTH and in_ready=0. Then assert out_ready and in_valid together: entries pop in order and count stays at DEPTH-1 after the first simultaneous pop and push.
REQ-017 Push 0xFC000000 (reserved op): out_invalid=1 and out_ctrl=0x000. Push 0x40816000 (mtc0): out_cp0we=1 and out_ctrl=0x000.
REQ-018 Fill 3 entries, then assert flush together with in_valid: the next cycle gives count=0 and out_valid=0, and the flushed-cycle instruction is absent.
REQ-019 Drop resetn between edges with 2 entries queued: count=0 immediately. After release, push 0x00000000 (sll): out_ctrl=0xC01.
REQ-020 Push 0x0000000C then 0x42000018: out_syscall=1 for the first, out_eret=1 for the second; pointer wrap is exercised over 3*DEPTH pushes.
